// File: rtl/param_updown_counter_sync.sv
// Purpose: synchronous up/down modulo counter with clamped parallel load, terminal-count flag and wrap pulse.
// Latency: 1 cycle from Load/En to count/wrap; tc is combinational. No backpressure (always accepts).
// Option: define PARAM_UPDOWN_COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module param_updown_counter_sync #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic             UpDn,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             at_zero;

    // A full binary range needs no clamp; the compare would be constant false.
    generate
        if (MODULUS == (64'd1 << WIDTH)) begin : g_full_range
            assign load_val = LoadVal;
        end else begin : g_clamp
            assign load_val = (LoadVal > MAXV) ? MAXV : LoadVal;
        end
    endgenerate

    assign at_max  = (count == MAXV);
    assign at_zero = (count == '0);
    assign tc      = UpDn ? at_max : at_zero;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (Load) begin
            count_nxt = load_val;
        end else if (En) begin
            if (UpDn) begin
                if (at_max) begin
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
                    count_nxt = count;
`else
                    count_nxt = '0;
`endif
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (at_zero) begin
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
                    count_nxt = count;
`else
                    count_nxt = MAXV;
`endif
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_param_updown_counter_sync.sv
// Bench for param_updown_counter_sync: a default 16-state instance and a 10-state instance,
// each tracked by an arithmetic reference model plus directed literal expectations.
module tb_param_updown_counter_sync;

`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int M0 = 16;
    localparam int M1 = 10;

    logic       Clk = 1'b0;
    logic       clr0, en0, updn0, load0;
    logic [3:0] lv0;
    logic [3:0] count0;
    logic       tc0, wrap0;
    logic       clr1, en1, updn1, load1;
    logic [3:0] lv1;
    logic [3:0] count1;
    logic       tc1, wrap1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    param_updown_counter_sync u0 (
        .Clk(Clk), .Clr(clr0), .En(en0), .UpDn(updn0), .Load(load0), .LoadVal(lv0),
        .count(count0), .tc(tc0), .wrap(wrap0)
    );

    param_updown_counter_sync #(.WIDTH(4), .MODULUS(10)) u1 (
        .Clk(Clk), .Clr(clr1), .En(en1), .UpDn(updn1), .Load(load1), .LoadVal(lv1),
        .count(count1), .tc(tc1), .wrap(wrap1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: step by +/-1 in plain integers, then fold back into 0..m-1.
    function automatic void model_step(input int c, input bit clr, input bit load, input int lv,
                                       input bit en, input bit updn, input int m,
                                       output int nc, output bit nw);
        int t;
        nc = c;
        nw = 1'b0;
        if (clr) begin
            nc = 0;
        end else if (load) begin
            nc = (lv < m) ? lv : m - 1;
        end else if (en) begin
            t = updn ? c + 1 : c - 1;
            if (t < 0 || t >= m) begin
                nw = 1'b1;
                nc = SAT ? c : (t + m) % m;
            end else begin
                nc = t;
            end
        end
    endfunction

    int m0c, m1c;
    bit m0w, m1w;
    bit m0v = 1'b0, m1v = 1'b0;

    always @(posedge Clk) begin
        int nc;
        bit nw;
        model_step(m0c, clr0, load0, int'(lv0), en0, updn0, M0, nc, nw);
        m0c = nc; m0w = nw;
        if (clr0) m0v = 1'b1;
        model_step(m1c, clr1, load1, int'(lv1), en1, updn1, M1, nc, nw);
        m1c = nc; m1w = nw;
        if (clr1) m1v = 1'b1;
    end

    always @(negedge Clk) begin
        if (m0v) begin
            chk("u0.count", int'(count0), m0c);
            chk("u0.wrap", int'(wrap0), int'(m0w));
            chk("u0.tc", int'(tc0), int'((updn0 && m0c == M0 - 1) || (!updn0 && m0c == 0)));
        end
        if (m1v) begin
            chk("u1.count", int'(count1), m1c);
            chk("u1.wrap", int'(wrap1), int'(m1w));
            chk("u1.tc", int'(tc1), int'((updn1 && m1c == M1 - 1) || (!updn1 && m1c == 0)));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    int leg[17] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15};

    initial begin
        clr0 = 1'b1; en0 = 1'b0; updn0 = 1'b0; load0 = 1'b0; lv0 = 4'd0;
        clr1 = 1'b1; en1 = 1'b0; updn1 = 1'b1; load1 = 1'b0; lv1 = 4'd0;
        step();
        step();
        chk("reset count0", int'(count0), 0);
        chk("reset wrap0", int'(wrap0), 0);
        chk("reset tc0 down", int'(tc0), 1);
        chk("reset count1", int'(count1), 0);
        chk("reset tc1 up", int'(tc1), 0);

        // Legacy down sequence on the default instance.
        clr0 = 1'b0; clr1 = 1'b0; en0 = 1'b1; updn0 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (!SAT) begin
                chk("legacy count", int'(count0), leg[i]);
                chk("legacy wrap", int'(wrap0), int'(leg[i] == 15));
                if (leg[i] == 0) chk("legacy tc", int'(tc0), 1);
            end
        end
        en0 = 1'b0;

        // Modulus-10 up count.
        en1 = 1'b1; updn1 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (!SAT) chk("mod10 count", int'(count1), i % 10);
            if (i == 9) chk("mod10 tc at 9", int'(tc1), 1);
            if (!SAT) chk("mod10 wrap", int'(wrap1), int'(i == 10));
        end
        en1 = 1'b0;

        // Load and clamp.
        load1 = 1'b1; lv1 = 4'd7;
        step();
        chk("load 7", int'(count1), 7);
        lv1 = 4'd13;
        step();
        chk("load clamp", int'(count1), 9);
        chk("load clamp wrap", int'(wrap1), 0);
        lv1 = 4'd4; en1 = 1'b1; updn1 = 1'b1;
        step();
        chk("load beats en", int'(count1), 4);
        en1 = 1'b0; lv1 = 4'd5;
        step();
        chk("load 5", int'(count1), 5);

        // Clr beats Load, then hold.
        clr1 = 1'b1; lv1 = 4'd3;
        step();
        chk("clr beats load", int'(count1), 0);
        chk("clr wrap", int'(wrap1), 0);
        clr1 = 1'b0; lv1 = 4'd6;
        step();
        load1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold count", int'(count1), 6);
            chk("hold tc", int'(tc1), 0);
            chk("hold wrap", int'(wrap1), 0);
        end

        // Direction flip at the top of the range.
        load0 = 1'b1; lv0 = 4'd15; updn0 = 1'b1;
        step();
        load0 = 1'b0;
        chk("flip tc up", int'(tc0), 1);
        updn0 = 1'b0;
        #1;
        chk("flip tc down", int'(tc0), 0);
        en0 = 1'b1;
        step();
        chk("flip count", int'(count0), 14);
        chk("flip wrap", int'(wrap0), 0);
        en0 = 1'b0;

        if (SAT) begin
            load0 = 1'b1; lv0 = 4'd15;
            step();
            load0 = 1'b0; en0 = 1'b1; updn0 = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("sat up count", int'(count0), 15);
                chk("sat up wrap", int'(wrap0), 1);
            end
            en0 = 1'b0; load0 = 1'b1; lv0 = 4'd0;
            step();
            load0 = 1'b0; en0 = 1'b1; updn0 = 1'b0;
            step();
            chk("sat down count", int'(count0), 0);
            chk("sat down wrap", int'(wrap0), 1);
            en0 = 1'b0;
        end

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
